// File: rtl/conv_frame_encoder_pkg.sv
// Shared convolutional-code constants and constraint-length decode helpers,
// common to the frame encoder and the Viterbi decoder configuration path.
package conv_frame_encoder_pkg;

  localparam int MAX_CONSTRAINT_LENGTH = 9;
  localparam int MAX_CODE_RATE         = 3;

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam logic [1:0] CONSTR_LEN_3 = 2'b00;
  localparam logic [1:0] CONSTR_LEN_5 = 2'b01;
  localparam logic [1:0] CONSTR_LEN_7 = 2'b10;
  localparam logic [1:0] CONSTR_LEN_9 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  // K = 2*code + 3, giving 3/5/7/9 for codes 00/01/10/11.
  function automatic logic [3:0] constr_len_to_k(input logic [1:0] constr_len);
    return {1'b0, constr_len, 1'b0} + 4'd3;
  endfunction

  function automatic logic [MAX_CONSTRAINT_LENGTH-1:0] constr_len_to_mask(
    input logic [1:0] constr_len
  );
    logic [MAX_CONSTRAINT_LENGTH-1:0] mask;
    logic [3:0]                       k;
    k    = constr_len_to_k(constr_len);
    mask = '0;
    for (int j = 0; j < MAX_CONSTRAINT_LENGTH; j++) begin
      mask[j] = (j < int'(k));
    end
    return mask;
  endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational parity generator: one coded symbol from the shift history,
// the current input bit, the generator polynomials and the active tap mask.
module conv_sym_gen
  import conv_frame_encoder_pkg::*;
#(
  parameter int MAX_K = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_R = MAX_CODE_RATE
) (
  input  logic [MAX_K-2:0]            hist_i,
  input  logic                        bit_i,
  input  logic [MAX_R-1:0][MAX_K-1:0] poly_i,
  input  logic [MAX_K-1:0]            mask_i,
  input  logic                        rate_i,
  output logic [MAX_R-1:0]            sym_o
);

  logic [MAX_K-1:0] window;

  assign window = {hist_i, bit_i};

  always_comb begin
    sym_o = '0;
    for (int r = 0; r < MAX_R; r++) begin
      sym_o[r] = ^(poly_i[r] & mask_i & window);
      // Third parity bit only exists at rate 1/3.
      if (r >= 2 && rate_i == CODE_RATE_2) begin
        sym_o[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-based convolutional encoder: FRAME_BITS message bits in, one symbol per
// bit out, followed by K-1 zero-tail symbols so the decoder ends in state 0.
module conv_frame_encoder
  import conv_frame_encoder_pkg::*;
#(
  parameter int FRAME_BITS = 128,
  parameter int MAX_K      = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_R      = MAX_CODE_RATE
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        i_code_rate,
  input  logic [1:0]                  i_constr_len,
  input  logic [MAX_R-1:0][MAX_K-1:0] i_gen_poly,
  input  logic                        i_bit_valid,
  input  logic                        i_bit,
  output logic                        o_bit_ready,
  output logic                        o_sym_valid,
  output logic [MAX_R-1:0]            o_sym,
  output logic                        o_sym_last,
  input  logic                        i_sym_ready,
  output logic                        o_frame_done,
  output logic                        o_busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  enc_state_e state_q, state_d;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       tail_cnt_q, tail_cnt_d;
  logic [MAX_K-2:0] hist_q, hist_d;
  logic [MAX_R-1:0] sym_q, sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic             sym_last_q, sym_last_d;
  logic             done_q, done_d;

  logic                        rate_q;
  logic [1:0]                  constr_len_q;
  logic [MAX_R-1:0][MAX_K-1:0] poly_q;

  logic                        eff_rate;
  logic [1:0]                  eff_constr_len;
  logic [MAX_R-1:0][MAX_K-1:0] eff_poly;
  logic [3:0]                  k_eff;
  logic [MAX_K-1:0]            mask_eff;

  logic [MAX_K-2:0] gen_hist;
  logic             gen_bit;
  logic [MAX_R-1:0] gen_sym;

  logic             slot_free;
  logic             bit_ready;
  logic             bit_fire;
  logic             tail_fire;
  logic             tail_last;
  logic             cfg_load;
  logic [CNT_W-1:0] cnt_next;
  logic             data_end;

  // The output slot can take a new symbol when empty or being drained this cycle.
  assign slot_free = !sym_valid_q || i_sym_ready;
  assign bit_ready = (state_q == ST_IDLE || state_q == ST_DATA) && slot_free && !done_q;
  assign bit_fire  = i_bit_valid && bit_ready;
  assign cfg_load  = (state_q == ST_IDLE) && bit_fire;

  // While idle the first bit is encoded with the live configuration, which is
  // latched on the same edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_rate       = i_code_rate;
      eff_constr_len = i_constr_len;
      eff_poly       = i_gen_poly;
    end else begin
      eff_rate       = rate_q;
      eff_constr_len = constr_len_q;
      eff_poly       = poly_q;
    end
  end

  assign k_eff    = constr_len_to_k(eff_constr_len);
  assign mask_eff = MAX_K'(constr_len_to_mask(eff_constr_len));
  assign gen_hist = (state_q == ST_IDLE) ? '0 : hist_q;
  assign gen_bit  = (state_q == ST_TAIL) ? 1'b0 : i_bit;

  conv_sym_gen #(
    .MAX_K(MAX_K),
    .MAX_R(MAX_R)
  ) u_sym_gen (
    .hist_i(gen_hist),
    .bit_i (gen_bit),
    .poly_i(eff_poly),
    .mask_i(mask_eff),
    .rate_i(eff_rate),
    .sym_o (gen_sym)
  );

  assign cnt_next  = (state_q == ST_IDLE) ? CNT_W'(1) : bit_cnt_q + CNT_W'(1);
  assign data_end  = (cnt_next == CNT_W'(FRAME_BITS));
  assign tail_fire = (state_q == ST_TAIL) && slot_free;
  assign tail_last = tail_fire && ({1'b0, tail_cnt_q} == k_eff - 4'd2);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    hist_d      = hist_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    done_d      = 1'b0;

    if (sym_valid_q && i_sym_ready) begin
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (bit_fire) begin
          if (state_q == ST_IDLE) begin
            hist_d    = '0;
            hist_d[0] = i_bit;
          end else begin
            hist_d = {hist_q[MAX_K-3:0], i_bit};
          end
          bit_cnt_d   = cnt_next;
          sym_d       = gen_sym;
          sym_valid_d = 1'b1;
          sym_last_d  = 1'b0;
          if (data_end) begin
            state_d    = ST_TAIL;
            tail_cnt_d = 3'd0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_TAIL: begin
        if (tail_fire) begin
          hist_d      = {hist_q[MAX_K-3:0], 1'b0};
          tail_cnt_d  = tail_cnt_q + 3'd1;
          sym_d       = gen_sym;
          sym_valid_d = 1'b1;
          sym_last_d  = tail_last;
          if (tail_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (sym_valid_q && sym_last_q && i_sym_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tail_cnt_q  <= '0;
      hist_q      <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      hist_q      <= hist_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      done_q      <= done_d;
    end
  end

  // Configuration is captured only at frame start and ignored until the next one.
  always_ff @(posedge sys_clk) begin
    if (cfg_load) begin
      rate_q       <= i_code_rate;
      constr_len_q <= i_constr_len;
      poly_q       <= i_gen_poly;
    end
  end

  assign o_bit_ready  = bit_ready && !rst;
  assign o_sym_valid  = sym_valid_q;
  assign o_sym        = sym_q;
  assign o_sym_last   = sym_last_q;
  assign o_frame_done = done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: small K=3 frames with hand-computed
// symbols plus a K=9, 128-bit frame against a bit-serial reference model.
module tb_conv_frame_encoder;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic           rst, rate, valid, bitv, sready, sel;
  logic [1:0]     cl;
  logic [2:0][8:0] poly;

  logic a_bv, a_sr, b_bv, b_sr;
  assign a_bv = valid & ~sel;
  assign a_sr = sready & ~sel;
  assign b_bv = valid & sel;
  assign b_sr = sready & sel;

  logic       a_rdy, a_sv, a_last, a_done, a_busy;
  logic       b_rdy, b_sv, b_last, b_done, b_busy;
  logic [2:0] a_sym, b_sym;

  logic       rdy, sv, last, done, busy;
  logic [2:0] sym;
  assign rdy  = sel ? b_rdy  : a_rdy;
  assign sv   = sel ? b_sv   : a_sv;
  assign last = sel ? b_last : a_last;
  assign done = sel ? b_done : a_done;
  assign busy = sel ? b_busy : a_busy;
  assign sym  = sel ? b_sym  : a_sym;

  conv_frame_encoder #(.FRAME_BITS(4), .MAX_K(9), .MAX_R(3)) u_dut_a (
    .sys_clk(sys_clk), .rst(rst), .i_code_rate(rate), .i_constr_len(cl),
    .i_gen_poly(poly), .i_bit_valid(a_bv), .i_bit(bitv), .o_bit_ready(a_rdy),
    .o_sym_valid(a_sv), .o_sym(a_sym), .o_sym_last(a_last), .i_sym_ready(a_sr),
    .o_frame_done(a_done), .o_busy(a_busy)
  );

  conv_frame_encoder #(.FRAME_BITS(128), .MAX_K(9), .MAX_R(3)) u_dut_b (
    .sys_clk(sys_clk), .rst(rst), .i_code_rate(rate), .i_constr_len(cl),
    .i_gen_poly(poly), .i_bit_valid(b_bv), .i_bit(bitv), .o_bit_ready(b_rdy),
    .o_sym_valid(b_sv), .o_sym(b_sym), .o_sym_last(b_last), .i_sym_ready(b_sr),
    .o_frame_done(b_done), .o_busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0] syms[$];
  logic       lasts[$];
  int         r_first, r_last, r_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one frame with a source that always offers the next bit and a sink
  // whose ready follows the pattern; optionally scrambles the config mid-frame.
  task automatic run_frame(input logic [127:0] bits, input int nbits, input int mode,
                           input int chg_at);
    int         bi;
    logic       held;
    logic [2:0] held_sym;
    logic       held_last;
    bi = 0; held = 1'b0; held_sym = '0; held_last = 1'b0;
    syms.delete(); lasts.delete();
    r_first = -1; r_last = -1; r_stall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == chg_at) begin
        poly = ~poly;
        cl   = 2'b00;
        rate = ~rate;
      end
      valid  = (bi < nbits);
      bitv   = (bi < nbits) ? bits[bi] : 1'b0;
      sready = (mode == 0) || (cyc % 3 == 0);
      #1;
      if (held && (!sv || sym !== held_sym || last !== held_last)) r_stall++;
      held = 1'b0;
      if (valid && rdy) begin
        if (r_first < 0) r_first = cyc;
        bi++;
      end
      if (sv && !sready) begin
        if (rdy) r_stall++;
        held = 1'b1; held_sym = sym; held_last = last;
      end
      if (sv && sready) begin
        syms.push_back(sym);
        lasts.push_back(last);
        if (last) r_last = cyc;
      end
      @(posedge sys_clk); #1;
      if (r_last >= 0) break;
    end
    valid  = 1'b0;
    bitv   = 1'b0;
    sready = 1'b0;
  endtask

  task automatic check_small(input string tag, input logic [17:0] exp,
                             input int exp_first, input int exp_last);
    logic [5:0] lv;
    lv = '0;
    check({tag, "_count"}, 32'(syms.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_sym%0d", tag, i),
            32'((i < syms.size()) ? syms[i] : 3'bxxx), 32'(exp[i*3 +: 3]));
      if (i < lasts.size()) lv[i] = lasts[i];
    end
    check({tag, "_lastpos"}, 32'(lv), 32'(6'b100000));
    check({tag, "_first_acc"}, 32'(r_first), 32'(exp_first));
    check({tag, "_last_cyc"}, 32'(r_last), 32'(exp_last));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [2:0] model_sym(input logic [127:0] bits, input int n,
                                           input int t, input logic [2:0][8:0] p,
                                           input int k, input logic r);
    logic [2:0] s;
    logic       x;
    int         idx;
    s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < k; j++) begin
        idx = t - j;
        x   = (idx >= 0 && idx < n) ? bits[idx] : 1'b0;
        s[i] = s[i] ^ (p[i][j] & x);
      end
    end
    if (!r) s[2] = 1'b0;
    return s;
  endfunction

  task automatic check_k9(input string tag, input logic [127:0] bits,
                          input logic [2:0][8:0] p, input logic r);
    int mism, nlast;
    mism = 0; nlast = 0;
    for (int t = 0; t < syms.size(); t++) begin
      if (syms[t] !== model_sym(bits, 128, t, p, 9, r)) mism++;
      if (lasts[t]) nlast++;
    end
    check({tag, "_count"}, 32'(syms.size()), 32'd136);
    check({tag, "_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_nlast"}, 32'(nlast), 32'd1);
    check({tag, "_last_is_final"}, 32'((syms.size() > 0) ? lasts[syms.size()-1] : 1'b0), 32'd1);
  endtask

  logic [127:0]    rbits;
  logic [2:0][8:0] psave;

  initial begin
    rst = 1'b1; sel = 1'b0; valid = 1'b0; bitv = 1'b0; sready = 1'b0;
    rate = 1'b0; cl = 2'b00;
    poly[0] = 9'h007; poly[1] = 9'h005; poly[2] = 9'h000;
    repeat (2) @(posedge sys_clk);
    #1;
    valid = 1'b1;
    #1;
    check("rst_bit_ready", 32'(rdy), 32'd0);
    check("rst_sym_valid", 32'(sv), 32'd0);
    check("rst_sym", 32'(sym), 32'd0);
    check("rst_last_done_busy", 32'({last, done, busy}), 32'd0);
    valid = 1'b0;
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk); #1;

    // K=3, polys 7/5, rate 1/2, bits 1,0,1,1
    run_frame(128'b1101, 4, 0, -1);
    check_small("r2", {3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3}, 0, 6);

    // Back-to-back at rate 1/3, poly2 = 3; first bit waits out the done cycle
    rate = 1'b1; poly[2] = 9'h003;
    run_frame(128'b1101, 4, 0, -1);
    check_small("r3_b2b", {3'b011, 3'b110, 3'b010, 3'b100, 3'b101, 3'b111}, 1, 7);
    @(posedge sys_clk); #1;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Sink stalls two of every three cycles
    rate = 1'b0; poly[2] = 9'h000;
    run_frame(128'b1101, 4, 1, -1);
    check_small("stall", {3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3}, 0, 18);
    check("stall_hold_and_ready", 32'(r_stall), 32'd0);
    @(posedge sys_clk); #1;

    // Reset in the middle of DATA
    valid = 1'b1; bitv = 1'b1; sready = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({sv, sym, last, busy, rdy, done}), 32'd0);
    valid = 1'b0; bitv = 1'b0; sready = 1'b0;
    @(negedge sys_clk) rst = 1'b0;
    @(posedge sys_clk); #1;
    run_frame(128'b1101, 4, 0, -1);
    check_small("post_rst", {3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3}, 0, 6);

    // K=9, 128 random bits, config scrambled mid-frame
    sel = 1'b1; rate = 1'b0; cl = 2'b11;
    poly[0] = 9'h171; poly[1] = 9'h1EB; poly[2] = 9'h1B5;
    psave = poly;
    rbits = {$urandom, $urandom, $urandom, $urandom};
    run_frame(rbits, 128, 0, 40);
    check_k9("k9_r2", rbits, psave, 1'b0);
    check("k9_r2_last_cyc", 32'(r_last), 32'd136);
    check("k9_r2_done", 32'(done), 32'd1);

    // Back-to-back K=9 frame at rate 1/3 with stalls
    poly = psave; cl = 2'b11; rate = 1'b1;
    rbits = {$urandom, $urandom, $urandom, $urandom};
    run_frame(rbits, 128, 1, 60);
    check_k9("k9_r3", rbits, psave, 1'b1);
    check("k9_r3_first_acc", 32'(r_first), 32'd1);
    check("k9_r3_last_cyc", 32'(r_last), 32'd408);
    check("k9_r3_stall", 32'(r_stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
